gray_conv_arbiter: RTL and testbench
====================================

// Module: gray_conv_arbiter
// PURPOSE
//  Shares one 4-bit binary-to-Gray conversion datapath between NREQ requesters.
//  Round-robin arbitration, registered operand/result, valid/ready response channel.
//  Sits between encoder-side clients (position counters, FIFO pointers) and the
//  shared converter, so only one conversion stage is instantiated per cluster.
// PARAMETERS
//  NREQ   4   number of requesters (>=2)
//  W      4   operand/result width in bits (>=2)
// PORTS
//  clk        in   1          single clock, all state updates on rising edge
//  rst_n      in   1          reset, synchronous, active-low
//  req        in   NREQ       per-requester request level
//  req_data   in   NREQ*W     operands, requester i at [i*W +: W]
//  gnt        out  NREQ       one-hot, 1-cycle pulse: operand of that requester captured
//  rsp_valid  out  1          result available
//  rsp_data   out  W          converted result
//  rsp_id     out  $clog2(NREQ) index of requester owning rsp_data
//  rsp_ready  in   1          consumer accepts result
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE, gnt=0, rsp_valid=0, rsp_data=0, rsp_id=0, ptr=0.
//    Reset wins over everything, including mid-conversion or pending response; result lost.
//  - FSM IDLE -> CONV -> RESP -> IDLE; all outputs registered.
//  - IDLE: if |req, winner = first set req searching ptr, ptr+1, ... wrapping mod NREQ;
//    op_q<=req_data[winner], id_q<=winner, gnt<=onehot(winner), ptr<=(winner+1)%NREQ,
//    state->CONV. If req==0: stay, no output change.
//  - CONV (1 cycle): gnt<=0; rsp_data<=op_q ^ (op_q>>1); rsp_id<=id_q; rsp_valid<=1; ->RESP.
//  - RESP: rsp_valid/rsp_data/rsp_id held stable while rsp_ready=0.
//    rsp_ready=1: rsp_valid<=0, ->IDLE. No new grant while in CONV or RESP.
//  - Latency: req sampled at edge t -> gnt high t+1..t+2 -> rsp_valid high from t+2.
//    Max throughput 1 result per 3 cycles (IDLE bubble after handshake is intentional).
//  - req only sampled in IDLE. Requester holds req/req_data until it sees gnt, then drops
//    req (req still high at next IDLE = new request). Data change after gnt is ignored.
//  - ptr wraps NREQ-1 -> 0. Non-power-of-2 NREQ legal; rsp_id never exceeds NREQ-1.
//  - rsp_ready while rsp_valid=0: ignored.
// CONFIGURATION
//  GRAY_DECODE_EN defined: extra input req_op [NREQ-1:0]; op captured with operand;
//    op=0 -> binary-to-Gray, op=1 -> Gray-to-binary (b[W-1]=g[W-1], b[i]=b[i+1]^g[i]).
//    Extra output rsp_op (1 bit) echoes op, same timing/reset as rsp_id.
//  GRAY_DECODE_EN undefined: req_op/rsp_op absent; always binary-to-Gray.
// STRUCTURE
//  Package gray_pkg: state enum typedef (IDLE/CONV/RESP), functions bin2gray(W)
//    and gray2bin(W), localparam ID_W = $clog2(NREQ) helper.
//  Sub-module rr_arbiter (NREQ): req + ptr in, one-hot winner + index out, combinational;
//    ptr register and FSM stay in gray_conv_arbiter.
// TESTING  (NREQ=4, W=4)
//  1 rst_n=0 for 3 cycles with req=4'b1111 -> gnt=0, rsp_valid=0 throughout; after release
//    first gnt=4'b0001.
//  2 only req[2], data 4'b1011, rsp_ready=1 -> gnt=4'b0100 one cycle later, next cycle
//    rsp_valid=1, rsp_data=4'b1110, rsp_id=2.
//  3 req=4'b1111 held, rsp_ready=1 -> gnt order 0,1,2,3,0, one grant every 3 cycles.
//  4 rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, gnt=0; rsp_ready=1 -> rsp_valid
//    drops next edge, next grant one cycle later.
//  5 req[1] sweeps data 0..15 -> rsp_data == d^(d>>1) each (e.g. 4'b1111 -> 4'b1000);
//    assert rst_n=0 during one RESP -> rsp_valid=0 next edge, next grant to req0 (ptr=0).
//  6 GRAY_DECODE_EN: req_op[3]=1, data 4'b1000 -> rsp_data=4'b1111, rsp_op=1, rsp_id=3.

Source files
------------

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared FSM state type and Gray code helpers for gray_conv_arbiter
package gray_pkg;

  typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

  // Index width for a requester count; at least one bit so single-bit ports stay legal.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int k = 1; k < 32; k++) b = b ^ (g >> k);
    return b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter
  import gray_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int ID_W = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  int          pos;
  logic [ID_W-1:0] pos_idx;

  always_comb begin
    grant   = '0;
    idx     = '0;
    any     = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos     = (int'(ptr) + k) % NREQ;
      pos_idx = ID_W'(pos);
      if (!any && req[pos_idx]) begin
        any            = 1'b1;
        grant[pos_idx] = 1'b1;
        idx            = pos_idx;
      end
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// rtl/gray_conv_arbiter.sv - round-robin shared binary/Gray converter; GRAY_DECODE_EN adds Gray-to-binary ops
module gray_conv_arbiter
  import gray_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 4,
  localparam int ID_W = id_w(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_data,
`ifdef GRAY_DECODE_EN
  input  logic [NREQ-1:0]   req_op,
`endif
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic [ID_W-1:0]   rsp_id,
`ifdef GRAY_DECODE_EN
  output logic              rsp_op,
`endif
  input  logic              rsp_ready
);

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [W-1:0]    op_q;
  logic [ID_W-1:0] id_q;
  logic [NREQ-1:0] win_onehot;
  logic [ID_W-1:0] win_idx;
  logic            win_any;
  logic [W-1:0]    conv_result;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (win_onehot),
    .idx   (win_idx),
    .any   (win_any)
  );

`ifdef GRAY_DECODE_EN
  logic dec_q;
  assign conv_result = dec_q ? W'(gray2bin(32'(op_q))) : W'(bin2gray(32'(op_q)));
`else
  assign conv_result = W'(bin2gray(32'(op_q)));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      ptr       <= '0;
      op_q      <= '0;
      id_q      <= '0;
`ifdef GRAY_DECODE_EN
      dec_q     <= 1'b0;
      rsp_op    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            op_q  <= req_data[win_idx*W +: W];
            id_q  <= win_idx;
            gnt   <= win_onehot;
            ptr   <= (win_idx == ID_W'(NREQ-1)) ? '0 : win_idx + 1'b1;
`ifdef GRAY_DECODE_EN
            dec_q <= req_op[win_idx];
`endif
            state <= CONV;
          end
        end
        CONV: begin
          gnt       <= '0;
          rsp_data  <= conv_result;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
`ifdef GRAY_DECODE_EN
          rsp_op    <= dec_q;
`endif
          state     <= RESP;
        end
        RESP: begin
          // Result held until accepted; the return through IDLE leaves one bubble cycle.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb/tb_gray_conv_arbiter.sv - randomized self-checking bench for gray_conv_arbiter
module tb_gray_conv_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req;
  logic [15:0]   req_data;
  logic [3:0]    req_op;
  logic [3:0]    gnt;
  logic          rsp_valid;
  logic [3:0]    rsp_data;
  logic [1:0]    rsp_id;
  logic          rsp_ready;
`ifdef GRAY_DECODE_EN
  logic          rsp_op;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr   = 0;
  int last_data = 0;

  always #5 clk = ~clk;

  gray_conv_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
`ifdef GRAY_DECODE_EN
    .req_op    (req_op),
`endif
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
`ifdef GRAY_DECODE_EN
    .rsp_op    (rsp_op),
`endif
    .rsp_ready (rsp_ready)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Gray code by definition: bit i differs from bit i+1 of the binary value.
  function automatic int ref_gray(input int d);
    int g = 0;
    for (int i = 0; i < W; i++)
      if (((d >> i) & 1) != ((d >> (i + 1)) & 1)) g += (1 << i);
    return g;
  endfunction

  // Inverse: binary value whose Gray code equals g.
  function automatic int ref_bin(input int g);
    for (int b = 0; b < (1 << W); b++)
      if (ref_gray(b) == g) return b;
    return -1;
  endfunction

  function automatic int ref_winner(input logic [3:0] r);
    for (int k = 0; k < NREQ; k++)
      if (r[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic do_txn(input logic [3:0] r, input logic [15:0] data, input logic [3:0] ops,
                        input int hold);
    int win;
    int d;
    int exp;
    req       = r;
    req_data  = data;
    req_op    = ops;
    rsp_ready = (hold == 0);
    win       = ref_winner(r);
    d         = (data >> (win * W)) & 15;
    exp       = ops[win] ? ref_bin(d) : ref_gray(d);
    m_ptr     = (win + 1) % NREQ;
    step();
    check("gnt", gnt, 1 << win);
    check("valid_early", rsp_valid, 0);
    step();
    check("gnt_pulse", gnt, 0);
    check("valid", rsp_valid, 1);
    check("data", rsp_data, exp);
    check("id", rsp_id, win);
`ifdef GRAY_DECODE_EN
    check("op", rsp_op, ops[win]);
`endif
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_data, exp);
      check("hold_id", rsp_id, win);
      check("hold_gnt", gnt, 0);
    end
    rsp_ready = 1'b1;
    step();
    check("valid_drop", rsp_valid, 0);
    last_data = exp;
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b1111; req_data = 16'h0; req_op = 4'b0; rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_gnt", gnt, 0);
      check("rst_valid", rsp_valid, 0);
      check("rst_data", rsp_data, 0);
      check("rst_id", rsp_id, 0);
    end
    rst_n = 1'b1;
    m_ptr = 0;
    do_txn(4'b1111, 16'h1234, 4'b0, 0);
    do_txn(4'b0100, 16'h0B00, 4'b0, 0);
    for (int i = 0; i < 5; i++) do_txn(4'b1111, 16'($urandom), 4'b0, 0);
    do_txn(4'b1111, 16'($urandom), 4'b0, 5);

    req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_gnt", gnt, 0);
      check("idle_valid", rsp_valid, 0);
      check("idle_data", rsp_data, last_data);
    end

    for (int d = 0; d < 16; d++)
      do_txn(4'b0010, 16'(d << 4), 4'b0, int'($urandom_range(0, 2)));

    req = 4'b0010; req_data = 16'h00F0; rsp_ready = 1'b0;
    step();
    step();
    check("pre_rst_valid", rsp_valid, 1);
    rst_n = 1'b0;
    step();
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_gnt", gnt, 0);
    rst_n = 1'b1;
    m_ptr = 0;
    do_txn(4'b1111, 16'h5A5A, 4'b0, 0);

    for (int i = 0; i < 30; i++)
      do_txn(4'($urandom_range(1, 15)), 16'($urandom), 4'b0, int'($urandom_range(0, 3)));

`ifdef GRAY_DECODE_EN
    do_txn(4'b1000, 16'h8000, 4'b1000, 0);
    for (int i = 0; i < 20; i++)
      do_txn(4'($urandom_range(1, 15)), 16'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
